// File: rtl/hx711_serial_reader.sv
// HX711 24-bit load-cell ADC reader: bit-bangs PD_SCK, shifts DOUT in MSB first, publishes signed samples.
// Define HX711_AVG_EN to publish a 4-frame boxcar average instead of every frame.
module hx711_serial_reader #(
   parameter int HALF_PER    = 100,
   parameter int GAIN_PULSES = 1,
   parameter int PDN_CYC     = 10000,
   parameter int TMO_CYC     = 20000000
) (
   input  logic               clk_100MHz,
   input  logic               rst,
   input  logic               DOUT,
   output logic               PD_SCK,
   output logic signed [23:0] RAW_VAL,
   output logic               DATA_VALID,
   output logic               NO_DATA
);

   localparam int PW = $clog2(HALF_PER);

   typedef enum logic [2:0] {CHIP_RST, WAIT_RDY, SHIFT, GAIN, DONE} state_t;

   state_t          state;
   logic            dout_meta;
   logic            dout_sync;
   logic [PW-1:0]   phase_cnt;
   logic [4:0]      bit_cnt;
   logic [31:0]     wait_cnt;
   logic [23:0]     shreg;
   logic            phase_end;

   assign phase_end = (phase_cnt == PW'(HALF_PER - 1));

`ifdef HX711_AVG_EN
   logic signed [25:0] acc;
   logic signed [25:0] acc_sum;
   logic signed [25:0] acc_avg;
   logic [1:0]         frm_cnt;

   assign acc_sum = acc + $signed({{2{shreg[23]}}, shreg});
   assign acc_avg = acc_sum >>> 2;
`endif

   // DOUT is asynchronous to our clock; idle-high reset value avoids a false ready.
   always_ff @(posedge clk_100MHz or posedge rst) begin
      if (rst) begin
         dout_meta <= 1'b1;
         dout_sync <= 1'b1;
      end else begin
         dout_meta <= DOUT;
         dout_sync <= dout_meta;
      end
   end

   always_ff @(posedge clk_100MHz or posedge rst) begin
      if (rst) begin
         state      <= CHIP_RST;
         PD_SCK     <= 1'b0;
         RAW_VAL    <= '0;
         DATA_VALID <= 1'b0;
         NO_DATA    <= 1'b0;
         phase_cnt  <= '0;
         bit_cnt    <= '0;
         wait_cnt   <= '0;
         shreg      <= '0;
`ifdef HX711_AVG_EN
         acc        <= '0;
         frm_cnt    <= '0;
`endif
      end else begin
         DATA_VALID <= 1'b0;
         case (state)
            CHIP_RST: begin
               if (wait_cnt == 32'(PDN_CYC)) begin
                  PD_SCK   <= 1'b0;
                  wait_cnt <= '0;
                  state    <= WAIT_RDY;
               end else begin
                  PD_SCK   <= 1'b1;
                  wait_cnt <= wait_cnt + 32'd1;
               end
            end

            WAIT_RDY: begin
               PD_SCK <= 1'b0;
               if (!dout_sync) begin
                  PD_SCK    <= 1'b1;
                  phase_cnt <= '0;
                  bit_cnt   <= '0;
                  wait_cnt  <= '0;
                  state     <= SHIFT;
               end else if (wait_cnt == 32'(TMO_CYC - 1)) begin
                  NO_DATA  <= 1'b1;
                  wait_cnt <= '0;
               end else begin
                  wait_cnt <= wait_cnt + 32'd1;
               end
            end

            // Data is sampled at the end of the high phase, well after the chip's rising-edge update.
            SHIFT: begin
               if (!phase_end) begin
                  phase_cnt <= phase_cnt + 1'b1;
               end else begin
                  phase_cnt <= '0;
                  if (PD_SCK) begin
                     PD_SCK <= 1'b0;
                     shreg  <= {shreg[22:0], dout_sync};
                  end else if (bit_cnt == 5'd23) begin
                     PD_SCK  <= 1'b1;
                     bit_cnt <= '0;
                     state   <= GAIN;
                  end else begin
                     PD_SCK  <= 1'b1;
                     bit_cnt <= bit_cnt + 5'd1;
                  end
               end
            end

            GAIN: begin
               if (!phase_end) begin
                  phase_cnt <= phase_cnt + 1'b1;
               end else begin
                  phase_cnt <= '0;
                  if (PD_SCK) begin
                     PD_SCK <= 1'b0;
                  end else if (bit_cnt == 5'(GAIN_PULSES - 1)) begin
                     bit_cnt <= '0;
                     state   <= DONE;
                  end else begin
                     PD_SCK  <= 1'b1;
                     bit_cnt <= bit_cnt + 5'd1;
                  end
               end
            end

            DONE: begin
               NO_DATA <= 1'b0;
               state   <= WAIT_RDY;
`ifdef HX711_AVG_EN
               frm_cnt <= frm_cnt + 2'd1;
               if (frm_cnt == 2'd3) begin
                  RAW_VAL    <= acc_avg[23:0];
                  DATA_VALID <= 1'b1;
                  acc        <= '0;
               end else begin
                  acc <= acc_sum;
               end
`else
               RAW_VAL    <= shreg;
               DATA_VALID <= 1'b1;
`endif
            end

            default: begin
               PD_SCK <= 1'b0;
               state  <= CHIP_RST;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_hx711_serial_reader.sv
// Scoreboard bench for hx711_serial_reader: an HX711 model feeds frames, a monitor checks every DATA_VALID.
`timescale 1ns/1ps
module tb_hx711_serial_reader;

   localparam int HP  = 6;
   localparam int G   = 1;
   localparam int PDN = 200;
   localparam int TMO = 1000;
`ifdef HX711_AVG_EN
   localparam int FPV = 4;
`else
   localparam int FPV = 1;
`endif

   logic        clk_100MHz = 1'b0;
   logic        rst = 1'b1;
   logic        DOUT = 1'b1;
   logic        PD_SCK;
   logic [23:0] RAW_VAL;
   logic        DATA_VALID;
   logic        NO_DATA;

   int checks = 0;
   int passes = 0;
   int exp_q[$];
   int avg_frames[$];

   int hi_w = 0;
   int pulse_cnt = 0;
   bit prev_dv = 1'b0;

   hx711_serial_reader #(
      .HALF_PER(HP), .GAIN_PULSES(G), .PDN_CYC(PDN), .TMO_CYC(TMO)
   ) dut (
      .clk_100MHz(clk_100MHz),
      .rst(rst),
      .DOUT(DOUT),
      .PD_SCK(PD_SCK),
      .RAW_VAL(RAW_VAL),
      .DATA_VALID(DATA_VALID),
      .NO_DATA(NO_DATA)
   );

   always #5 clk_100MHz = ~clk_100MHz;

   task automatic checkOutput(input string name, input longint actual, input longint expected);
      checks++;
      if (actual == expected) passes++;
      else $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, expected);
   endtask

   // Reference: each frame value as-is, or the floored mean of each group of four.
   task automatic modelFrame(input int v);
`ifdef HX711_AVG_EN
      int s, r;
      avg_frames.push_back(v);
      if (avg_frames.size() == 4) begin
         s = 0;
         foreach (avg_frames[k]) s += avg_frames[k];
         r = s % 4;
         if (r < 0) r += 4;
         exp_q.push_back((s - r) / 4);
         avg_frames.delete();
      end
`else
      exp_q.push_back(v);
`endif
   endtask

   task automatic waitRise(input int budget, output bit ok);
      bit prev;
      prev = PD_SCK;
      ok = 1'b0;
      for (int n = 0; n < budget; n++) begin
         @(negedge clk_100MHz);
         if (PD_SCK && !prev) begin
            ok = 1'b1;
            return;
         end
         prev = PD_SCK;
      end
   endtask

   // Behaves like the chip: ready low, new bit after each rising PD_SCK, DOUT high on the 25th pulse.
   task automatic applyStimulus(input logic [23:0] val, input int abort_bit);
      bit ok;
      int v;
      repeat ($urandom_range(2*HP + 10, 2*HP + 40)) @(negedge clk_100MHz);
      DOUT = 1'b0;
      for (int i = 0; i < 24; i++) begin
         waitRise(4*HP + 20, ok);
         if (!ok) begin
            checkOutput("sck_rise_timeout", 0, 1);
            DOUT = 1'b1;
            return;
         end
         DOUT = val[23-i];
         if (i == abort_bit) begin
            repeat (HP/2) @(negedge clk_100MHz);
            rst = 1'b1;
            #1;
            checkOutput("abort_sck_low", PD_SCK, 0);
            DOUT = 1'b1;
            repeat (3) @(negedge clk_100MHz);
            checkOutput("abort_raw_zero", RAW_VAL, 0);
            avg_frames.delete();
            rst = 1'b0;
            return;
         end
      end
      for (int g = 0; g < G; g++) begin
         waitRise(4*HP + 20, ok);
         if (!ok) begin
            checkOutput("gain_rise_timeout", 0, 1);
            DOUT = 1'b1;
            return;
         end
         if (g == 0) DOUT = 1'b1;
      end
      v = $signed(val);
      modelFrame(v);
   endtask

   task automatic measurePdn();
      int n;
      n = 0;
      for (int k = 0; k < 20 && !PD_SCK; k++) @(negedge clk_100MHz);
      if (PD_SCK) begin
         n = 1;
         while (n < 3*PDN) begin
            @(negedge clk_100MHz);
            if (PD_SCK) n++;
            else break;
         end
      end
      checkOutput("pdn_width", n, PDN);
   endtask

   task automatic measureTimeout();
      int n;
      n = 0;
      while (n < 3*TMO) begin
         @(negedge clk_100MHz);
         n++;
         if (NO_DATA) break;
      end
      checkOutput("no_data_latency", n, TMO);
   endtask

   // Monitor: pulse widths and counts, single-cycle strobe, scoreboard pop on every DATA_VALID.
   always @(negedge clk_100MHz) begin
      if (rst) begin
         hi_w = 0;
         pulse_cnt = 0;
         prev_dv = 1'b0;
      end else begin
         if (PD_SCK) begin
            hi_w++;
         end else if (hi_w != 0) begin
            if (hi_w == PDN) pulse_cnt = 0;
            else begin
               checkOutput("sck_high_width", hi_w, HP);
               pulse_cnt++;
            end
            hi_w = 0;
         end
         if (DATA_VALID) begin
            checkOutput("dv_single", prev_dv, 0);
            checkOutput("pulses_per_value", pulse_cnt, (24 + G) * FPV);
            checkOutput("no_data_clear", NO_DATA, 0);
            pulse_cnt = 0;
            if (exp_q.size() == 0) checkOutput("unexpected_dv", 1, 0);
            else checkOutput("raw_val", $signed(RAW_VAL), exp_q.pop_front());
         end
         prev_dv = DATA_VALID;
      end
   end

   initial begin
      int dirs[12] = '{32'h7FFFFF, 32'h800000, 32'hFFFFFF, 0,
                       100, 101, 102, -3, -1, -1, -1, -2};
      int w;
      repeat (3) @(negedge clk_100MHz);
      checkOutput("rst_pd_sck", PD_SCK, 0);
      checkOutput("rst_raw_val", RAW_VAL, 0);
      checkOutput("rst_data_valid", DATA_VALID, 0);
      checkOutput("rst_no_data", NO_DATA, 0);
      rst = 1'b0;

      measurePdn();
      checkOutput("pdn_no_dv", DATA_VALID, 0);
      checkOutput("pdn_raw_val", RAW_VAL, 0);
      measureTimeout();
      repeat (50) @(negedge clk_100MHz);
      checkOutput("no_data_sticky", NO_DATA, 1);

      foreach (dirs[i]) applyStimulus(24'(dirs[i]), -1);
      for (int i = 0; i < 8; i++) applyStimulus(24'($urandom), -1);

      applyStimulus(24'($urandom), 12);
      measurePdn();
      for (int i = 0; i < 4; i++) applyStimulus(24'($urandom), -1);

      w = 0;
      while (exp_q.size() != 0 && w < 4000) begin
         @(negedge clk_100MHz);
         w++;
      end
      checkOutput("scoreboard_drained", exp_q.size(), 0);
      repeat (20) @(negedge clk_100MHz);
      $display("%0d/%0d checks passed", passes, checks);
      $finish;
   end

endmodule
